// File: rtl/apu_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : apu_i2s_transmitter
// Purpose  : Latches the 9-bit mixer sample once per frame and sends it as
//            signed 16-bit Philips I2S, mono on both channels.
// Revision : 1.0 - initial release
// ============================================================================
module apu_i2s_transmitter #(
   parameter int BCLK_DIV = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [8:0] i_sample,
   input  logic       i_mute,
   output logic       o_sample_stb,
   output logic       o_bclk,
   output logic       o_lrclk,
   output logic       o_sdata
);

   localparam logic [7:0] c_DIV_TC = 8'(BCLK_DIV - 1);

   logic [7:0]  div_cnt_q, div_cnt_d;
   logic        bclk_q, bclk_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] word_q, word_d;
   logic [15:0] shreg_q, shreg_d;
   logic        stb_q, stb_d;
   logic        w_tc;
   logic        w_fall;
   logic [15:0] w_conv;

   always_comb begin
      w_tc      = (div_cnt_q == c_DIV_TC);
      w_fall    = w_tc && bclk_q;
      // Subtracting 256 from the unsigned word just flips its MSB; the
      // signed result then sits in bits 15..7 of the 16-bit word.
      w_conv    = i_mute ? 16'h0000 : {~i_sample[8], i_sample[7:0], 7'b000_0000};
      div_cnt_d = w_tc ? 8'd0 : div_cnt_q + 8'd1;
      bclk_d    = w_tc ? ~bclk_q : bclk_q;
      bit_cnt_d = bit_cnt_q;
      word_d    = word_q;
      shreg_d   = shreg_q;
      stb_d     = 1'b0;
      if (w_fall) begin
         bit_cnt_d = bit_cnt_q + 5'd1;
         if (bit_cnt_d == 5'd0) begin
            word_d = w_conv;
            stb_d  = 1'b1;
         end
         if (bit_cnt_d == 5'd1 || bit_cnt_d == 5'd17) begin
            shreg_d = word_q;
         end else begin
            shreg_d = {shreg_q[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         div_cnt_q <= 8'd0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= 5'd31;
         word_q    <= 16'h0000;
         shreg_q   <= 16'h0000;
         stb_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         word_q    <= word_d;
         shreg_q   <= shreg_d;
         stb_q     <= stb_d;
      end
   end

   assign o_bclk       = bclk_q;
   assign o_lrclk      = bit_cnt_q[4];
   assign o_sdata      = shreg_q[15];
   assign o_sample_stb = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_apu_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_i2s_transmitter
// Purpose  : Directed self-checking bench with a built-in I2S receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_i2s_transmitter;

   logic       i_clk;
   logic       i_rst_n;
   logic [8:0] i_sample;
   logic       i_mute;
   logic       o_sample_stb;
   logic       o_bclk;
   logic       o_lrclk;
   logic       o_sdata;

   apu_i2s_transmitter #(.BCLK_DIV(4)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_sample     (i_sample),
      .i_mute       (i_mute),
      .o_sample_stb (o_sample_stb),
      .o_bclk       (o_bclk),
      .o_lrclk      (o_lrclk),
      .o_sdata      (o_sdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic        prv_bclk = 1'b0;
   logic        prv_lr   = 1'b1;
   logic        prv_sd   = 1'b0;
   logic        rx_lr    = 1'b1;
   logic [15:0] rx_sh    = 16'h0000;
   logic [15:0] rx_left  = 16'h0000;
   logic [15:0] rx_right = 16'h0000;
   int          rx_lcnt  = 0;
   int          rx_rcnt  = 0;
   logic [8:0]  sw_in  [7];
   logic [15:0] sw_exp [7];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; checks that data/word-select only move when BCLK falls and
   // runs the receiver, which samples on BCLK rising.
   task automatic step();
      @(posedge i_clk);
      #1;
      if (!(prv_bclk && !o_bclk)) begin
         check("lrclk_stable", {31'd0, o_lrclk}, {31'd0, prv_lr});
         check("sdata_stable", {31'd0, o_sdata}, {31'd0, prv_sd});
      end
      if (!prv_bclk && o_bclk) begin
         if (o_lrclk != rx_lr) begin
            if (rx_lr) begin
               rx_right = {rx_sh[14:0], o_sdata};
               rx_rcnt++;
            end else begin
               rx_left = {rx_sh[14:0], o_sdata};
               rx_lcnt++;
            end
         end
         rx_sh = {rx_sh[14:0], o_sdata};
         rx_lr = o_lrclk;
      end
      prv_bclk = o_bclk;
      prv_lr   = o_lrclk;
      prv_sd   = o_sdata;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_stb(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!o_sample_stb && n < 300);
      check("stb_timeout", {31'd0, (n >= 300)}, 32'd0);
   endtask

   // Returns the next complete left word and the right word that follows it.
   task automatic get_frame(output logic [15:0] l, output logic [15:0] r);
      int lc;
      int rc;
      int n;
      n  = 0;
      lc = rx_lcnt;
      while (rx_lcnt == lc && n < 600) begin
         step();
         n++;
      end
      l  = rx_left;
      rc = rx_rcnt;
      while (rx_rcnt == rc && n < 1200) begin
         step();
         n++;
      end
      r = rx_right;
      check("frame_timeout", {31'd0, (n >= 1200)}, 32'd0);
   endtask

   initial begin
      int          n;
      logic [15:0] l;
      logic [15:0] r;

      sw_in[0] = 9'd0;   sw_exp[0] = 16'h8000;
      sw_in[1] = 9'd1;   sw_exp[1] = 16'h8080;
      sw_in[2] = 9'd255; sw_exp[2] = 16'hFF80;
      sw_in[3] = 9'd256; sw_exp[3] = 16'h0000;
      sw_in[4] = 9'd257; sw_exp[4] = 16'h0080;
      sw_in[5] = 9'd384; sw_exp[5] = 16'h4000;
      sw_in[6] = 9'd511; sw_exp[6] = 16'h7F80;

      i_rst_n  = 1'b0;
      i_sample = 9'd0;
      i_mute   = 1'b0;
      steps(3);
      check("rst_bclk",  {31'd0, o_bclk},       32'd0);
      check("rst_lrclk", {31'd0, o_lrclk},      32'd1);
      check("rst_sdata", {31'd0, o_sdata},      32'd0);
      check("rst_stb",   {31'd0, o_sample_stb}, 32'd0);

      // Startup: edges counted from the first edge with reset released.
      i_rst_n = 1'b1;
      steps(3);
      check("bclk_e3", {31'd0, o_bclk}, 32'd0);
      step();
      check("bclk_e4", {31'd0, o_bclk}, 32'd1);
      steps(3);
      check("bclk_e7",  {31'd0, o_bclk},       32'd1);
      check("lrclk_e7", {31'd0, o_lrclk},      32'd1);
      check("stb_e7",   {31'd0, o_sample_stb}, 32'd0);
      step();
      check("bclk_e8",  {31'd0, o_bclk},       32'd0);
      check("lrclk_e8", {31'd0, o_lrclk},      32'd0);
      check("stb_e8",   {31'd0, o_sample_stb}, 32'd1);
      step();
      check("stb_e9", {31'd0, o_sample_stb}, 32'd0);
      steps(6);
      check("sdata_e15", {31'd0, o_sdata}, 32'd0);
      step();
      check("msb_lag_e16", {31'd0, o_sdata}, 32'd1);
      wait_stb(n);
      check("stb_period_first", n, 32'd248);
      wait_stb(n);
      check("stb_period", n, 32'd256);

      // Conversion sweep through the receiver.
      for (int k = 0; k < 7; k++) begin
         i_sample = sw_in[k];
         wait_stb(n);
         get_frame(l, r);
         check($sformatf("sweep_left_%0d", sw_in[k]),  {16'd0, l}, {16'd0, sw_exp[k]});
         check($sformatf("sweep_right_%0d", sw_in[k]), {16'd0, r}, {16'd0, sw_exp[k]});
      end

      // Change one cycle after the strobe.
      i_sample = 9'd256;
      wait_stb(n);
      step();
      i_sample = 9'd384;
      get_frame(l, r);
      check("late_cur_left",   {16'd0, l}, 32'h0000);
      check("late_cur_right",  {16'd0, r}, 32'h0000);
      get_frame(l, r);
      check("late_next_left",  {16'd0, l}, 32'h4000);
      check("late_next_right", {16'd0, r}, 32'h4000);

      // Change right after the latching edge itself.
      i_sample = 9'd256;
      wait_stb(n);
      i_sample = 9'd384;
      get_frame(l, r);
      check("edge_cur_left",   {16'd0, l}, 32'h0000);
      check("edge_cur_right",  {16'd0, r}, 32'h0000);
      get_frame(l, r);
      check("edge_next_left",  {16'd0, l}, 32'h4000);
      check("edge_next_right", {16'd0, r}, 32'h4000);

      // Mute mid-frame only affects the next latch.
      i_sample = 9'd511;
      wait_stb(n);
      steps(64);
      i_mute = 1'b1;
      get_frame(l, r);
      check("mute_cur_left",   {16'd0, l}, 32'h7F80);
      check("mute_cur_right",  {16'd0, r}, 32'h7F80);
      get_frame(l, r);
      check("mute_next_left",  {16'd0, l}, 32'h0000);
      check("mute_next_right", {16'd0, r}, 32'h0000);
      i_mute = 1'b0;

      // Reset pulse during right-channel bit 7 of a 0x7F80 word.
      wait_stb(n);
      wait_stb(n);
      steps(205);
      check("pre_rst_bclk",  {31'd0, o_bclk},  32'd1);
      check("pre_rst_lrclk", {31'd0, o_lrclk}, 32'd1);
      check("pre_rst_sdata", {31'd0, o_sdata}, 32'd1);
      i_rst_n = 1'b0;
      step();
      check("mid_rst_bclk",  {31'd0, o_bclk},       32'd0);
      check("mid_rst_lrclk", {31'd0, o_lrclk},      32'd1);
      check("mid_rst_sdata", {31'd0, o_sdata},      32'd0);
      check("mid_rst_stb",   {31'd0, o_sample_stb}, 32'd0);
      i_rst_n = 1'b1;
      steps(3);
      check("re_bclk_e3", {31'd0, o_bclk}, 32'd0);
      step();
      check("re_bclk_e4", {31'd0, o_bclk}, 32'd1);
      steps(3);
      check("re_stb_e7", {31'd0, o_sample_stb}, 32'd0);
      step();
      check("re_bclk_e8",  {31'd0, o_bclk},       32'd0);
      check("re_lrclk_e8", {31'd0, o_lrclk},      32'd0);
      check("re_stb_e8",   {31'd0, o_sample_stb}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
